// File: rtl/ym3438_clk_phase_gen.sv
// ym3438_clk_phase_gen
//
// Two-phase enable generator for the OPN2 core. It divides MCLK into
// internal cycles of DIV MCLK periods. In each internal cycle it emits one
// c1 pulse and one c2 pulse, each one MCLK wide. It also keeps the slot
// cycle counter and the frame sync flag, and it stretches the core reset so
// that it always lasts to the end of a full frame.
//
// Parameters:
//   DIV            MCLK cycles per internal cycle (>= 2)
//   PHASE2_OFFSET  MCLK offset of c2 after c1 (1..DIV-1)
//   SLOTS          internal cycles per frame (2..32)
//
// Ports:
//   MCLK     in   master clock, all state updates on posedge
//   rst      in   synchronous active-high reset
//   clk_en   in   divider run enable; the divider freezes while low
//   c1       out  phase-1 enable, one MCLK wide, registered
//   c2       out  phase-2 enable, one MCLK wide, registered
//   phi_m    out  divided square wave (high for the first DIV/2 counts)
//   cycle    out  slot cycle, 0..SLOTS-1
//   sync     out  high while cycle == SLOTS-1
//   sys_rst  out  core reset, held until the first frame wrap after rst
//
// Build option:
//   YM3438_PHI_M_OUT_EN  when defined, phi_m is driven from a register.
//                        Otherwise phi_m is tied to 0 and has no register.

module ym3438_clk_phase_gen #(
    parameter int DIV           = 6,
    parameter int PHASE2_OFFSET = 3,
    parameter int SLOTS         = 24
) (
    input  logic       MCLK,
    input  logic       rst,
    input  logic       clk_en,
    output logic       c1,
    output logic       c2,
    output logic       phi_m,
    output logic [4:0] cycle,
    output logic       sync,
    output logic       sys_rst
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] C2_POS    = DIV_W'(PHASE2_OFFSET);
    localparam logic [4:0]       SLOT_LAST = 5'(SLOTS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] inc;

    always_comb begin
        inc = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    // Reset loads the divider with DIV-1. As a result, the first enabled
    // edge after release wraps the divider to 0 and fires c1.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            div_cnt <= DIV_LAST;
            c1      <= 1'b0;
            c2      <= 1'b0;
        end else if (clk_en) begin
            div_cnt <= inc;
            c1      <= (inc == '0);
            c2      <= (inc == C2_POS);
        end else begin
            c1      <= 1'b0;
            c2      <= 1'b0;
        end
    end

    // The counter advances on the registered c2. It therefore moves one
    // edge after c2 is seen high. sys_rst drops on the same edge where the
    // counter wraps.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            cycle   <= '0;
            sys_rst <= 1'b1;
        end else if (c2) begin
            if (cycle == SLOT_LAST) begin
                cycle   <= '0;
                sys_rst <= 1'b0;
            end else begin
                cycle   <= cycle + 1'b1;
            end
        end
    end

    always_comb begin
        sync = (cycle == SLOT_LAST);
    end

`ifdef YM3438_PHI_M_OUT_EN
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

    logic phi_q;

    always_ff @(posedge MCLK) begin
        if (rst) begin
            phi_q <= 1'b0;
        end else if (clk_en) begin
            phi_q <= (inc < DIV_HALF);
        end
    end

    assign phi_m = phi_q;
`else
    assign phi_m = 1'b0;
`endif

endmodule

// File: tb/tb_ym3438_clk_phase_gen.sv
// Testbench for ym3438_clk_phase_gen.
// Instance a uses the default parameters (DIV=6, PHASE2_OFFSET=3, SLOTS=24).
// Instance b uses DIV=4, PHASE2_OFFSET=2, SLOTS=2.
// Both instances share the reset. Only instance a sees the clk_en gap.

module tb_ym3438_clk_phase_gen;

`ifdef YM3438_PHI_M_OUT_EN
    localparam bit PHI_EN = 1'b1;
`else
    localparam bit PHI_EN = 1'b0;
`endif

    logic       MCLK;
    logic       rst;
    logic       clk_en;
    logic       en_b;

    logic       a_c1, a_c2, a_phi, a_sync, a_sys;
    logic [4:0] a_cyc;
    logic       b_c1, b_c2, b_phi, b_sync, b_sys;
    logic [4:0] b_cyc;

    int checks = 0;
    int errors = 0;

    ym3438_clk_phase_gen dut_a (
        .MCLK    (MCLK),
        .rst     (rst),
        .clk_en  (clk_en),
        .c1      (a_c1),
        .c2      (a_c2),
        .phi_m   (a_phi),
        .cycle   (a_cyc),
        .sync    (a_sync),
        .sys_rst (a_sys)
    );

    ym3438_clk_phase_gen #(
        .DIV           (4),
        .PHASE2_OFFSET (2),
        .SLOTS         (2)
    ) dut_b (
        .MCLK    (MCLK),
        .rst     (rst),
        .clk_en  (en_b),
        .c1      (b_c1),
        .c2      (b_c2),
        .phi_m   (b_phi),
        .cycle   (b_cyc),
        .sync    (b_sync),
        .sys_rst (b_sys)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit rst;
        bit en;
        bit a_c1;
        bit a_c2;
        bit a_phi;
        int a_cyc;
        bit a_sys;
        bit b_c1;
        bit b_c2;
        bit b_phi;
        int b_cyc;
        bit b_sys;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit e,
                       input bit ac1, input bit ac2, input bit aphi,
                       input int acyc, input bit asys,
                       input bit bc1, input bit bc2, input bit bphi,
                       input int bcyc, input bit bsys);
        vec_t v;
        v.rst = r;     v.en = e;
        v.a_c1 = ac1;  v.a_c2 = ac2;  v.a_phi = aphi;
        v.a_cyc = acyc; v.a_sys = asys;
        v.b_c1 = bc1;  v.b_c2 = bc2;  v.b_phi = bphi;
        v.b_cyc = bcyc; v.b_sys = bsys;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    int c2_seen;
    bit found;

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        en_b   = 1'b1;

        // Each row is: rst en | a: c1 c2 phi cycle sys_rst | b: c1 c2 phi cycle sys_rst
        // The values are the state after the edge for that row.
        add(1,1, 0,0,0,0,1, 0,0,0,0,1);
        add(1,1, 0,0,0,0,1, 0,0,0,0,1);
        add(0,1, 1,0,1,0,1, 1,0,1,0,1);   // E1
        add(0,1, 0,0,1,0,1, 0,0,1,0,1);   // E2
        add(0,1, 0,0,1,0,1, 0,1,0,0,1);   // E3
        add(0,1, 0,1,0,0,1, 0,0,0,1,1);   // E4
        add(0,1, 0,0,0,1,1, 1,0,1,1,1);   // E5
        add(0,1, 0,0,0,1,1, 0,0,1,1,1);   // E6
        add(0,1, 1,0,1,1,1, 0,1,0,1,1);   // E7
        add(0,1, 0,0,1,1,1, 0,0,0,0,0);   // E8: b wraps, sys_rst falls
        add(0,1, 0,0,1,1,1, 1,0,1,0,0);   // E9
        add(0,1, 0,1,0,1,1, 0,0,1,0,0);   // E10
        add(0,1, 0,0,0,2,1, 0,1,0,0,0);   // E11
        add(0,1, 0,0,0,2,1, 0,0,0,1,0);   // E12
        add(0,1, 1,0,1,2,1, 1,0,1,1,0);   // E13
        add(0,1, 0,0,1,2,1, 0,0,1,1,0);   // E14

        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            clk_en = vecs[i].en;
            tick();
            chk("a_c1",    a_c1,  vecs[i].a_c1);
            chk("a_c2",    a_c2,  vecs[i].a_c2);
            chk("a_phi",   a_phi, PHI_EN ? vecs[i].a_phi : 0);
            chk("a_cycle", a_cyc, vecs[i].a_cyc);
            chk("a_sync",  a_sync, (vecs[i].a_cyc == 23) ? 1 : 0);
            chk("a_sys",   a_sys, vecs[i].a_sys);
            chk("b_c1",    b_c1,  vecs[i].b_c1);
            chk("b_c2",    b_c2,  vecs[i].b_c2);
            chk("b_phi",   b_phi, PHI_EN ? vecs[i].b_phi : 0);
            chk("b_cycle", b_cyc, vecs[i].b_cyc);
            chk("b_sync",  b_sync, (vecs[i].b_cyc == 1) ? 1 : 0);
            chk("b_sys",   b_sys, vecs[i].b_sys);
        end

        // Full-frame stretch. c2 already fired at E4 and E10.
        c2_seen = 2;
        for (int n = 15; n <= 143; n++) begin
            tick();
            chk("frame_c1", a_c1, ((n - 1) % 6 == 0) ? 1 : 0);
            chk("frame_c2", a_c2, ((n - 1) % 6 == 3) ? 1 : 0);
            if (a_c2) c2_seen++;
            if (n == 137) begin
                chk("c2_count_23", c2_seen, 23);
                chk("cycle_23",    a_cyc, 23);
                chk("sync_23",     a_sync, 1);
            end
            if (n == 142) chk("sys_rst_E142", a_sys, 1);
            if (n == 143) begin
                chk("cycle_wrap_E143", a_cyc, 0);
                chk("sys_rst_E143",    a_sys, 0);
                chk("sync_E143",       a_sync, 0);
            end
        end

        // clk_en gap of 5 MCLK between c1 and c2.
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (a_c1) found = 1'b1;
        end
        chk("gap_find_c1", found, 1);
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gap_c1",    a_c1, 0);
            chk("gap_c2",    a_c2, 0);
            chk("gap_cycle", a_cyc, 0);
            chk("gap_phi",   a_phi, PHI_EN ? 1 : 0);
        end
        clk_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("resume_c1", a_c1, (k == 6) ? 1 : 0);
            chk("resume_c2", a_c2, (k == 3 || k == 9) ? 1 : 0);
            if (k == 4) chk("resume_cycle", a_cyc, 1);
        end

        // Reset in the middle of frame cycle 10, on the edge that would fire c2.
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (a_c1 && a_cyc == 5'd10) found = 1'b1;
        end
        chk("find_cycle10", found, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_c1",    a_c1, 0);
        chk("mid_rst_c2",    a_c2, 0);
        chk("mid_rst_cycle", a_cyc, 0);
        chk("mid_rst_sys",   a_sys, 1);
        chk("mid_rst_sync",  a_sync, 0);
        chk("mid_rst_phi",   a_phi, 0);
        rst = 1'b0;
        for (int n = 1; n <= 143; n++) begin
            tick();
            if (n == 1)   chk("rerun_c1_E1", a_c1, 1);
            if (n == 4)   chk("rerun_c2_E4", a_c2, 1);
            if (n == 7)   chk("rerun_b_sys_E7", b_sys, 1);
            if (n == 8)   chk("rerun_b_sys_E8", b_sys, 0);
            if (n == 142) chk("rerun_sys_E142", a_sys, 1);
            if (n == 143) begin
                chk("rerun_sys_E143",   a_sys, 0);
                chk("rerun_cycle_E143", a_cyc, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ym3438_clk_phase_gen.md
# ym3438_clk_phase_gen

Two-phase enable generator for the OPN2 core. It divides MCLK and drives the `c1`/`c2` enables that clock every two-phase shift register, counter and latch in the chip. It also tracks the slot cycle counter, the frame sync flag and a frame-stretched internal reset. It is the single source of phase timing that all downstream storage primitives consume.

## Interface
Parameters:
- `DIV`, 6: MCLK cycles per internal cycle; legal range ≥ 2.
- `PHASE2_OFFSET`, 3: MCLK offset of the `c2` pulse after the `c1` pulse; legal range 1..DIV-1.
- `SLOTS`, 24: internal cycles per frame; legal range 2..32.

Ports:
- `MCLK`, input, 1: master clock; all state updates on the posedge.
- `rst`, input, 1: reset; synchronous, active-high; clock MCLK.
- `clk_en`, input, 1: divider run enable; when low, the divider freezes.
- `c1`, output, 1: phase-1 enable; one MCLK wide, registered.
- `c2`, output, 1: phase-2 enable; one MCLK wide, registered.
- `phi_m`, output, 1: divided square-wave clock for external/test use.
- `cycle`, output, 5: current slot cycle, 0..SLOTS-1.
- `sync`, output, 1: high while `cycle == SLOTS-1`.
- `sys_rst`, output, 1: internal reset for the core, stretched to a full frame.

## Operation
- Internal state: divider `div_cnt` (width clog2(DIV)), `c1`, `c2`, `phi_m`, `cycle`, `sys_rst`. Let `inc = (div_cnt == DIV-1) ? 0 : div_cnt+1`.
- On an edge with `rst` high:
  - `div_cnt` ← DIV-1.
  - `c1`, `c2` and `phi_m` ← 0.
  - `cycle` ← 0.
  - `sys_rst` ← 1.
- On an edge with `rst` low and `clk_en` high:
  - `div_cnt` ← `inc`.
  - `c1` ← (`inc` == 0).
  - `c2` ← (`inc` == PHASE2_OFFSET).
  - `phi_m` ← (`inc` < DIV/2), using integer division.
- On an edge with `rst` low and `clk_en` low:
  - `div_cnt` and `phi_m` hold.
  - `c1` and `c2` ← 0, so no enable fires while frozen.
- Cycle counter: on an edge with `rst` low and registered `c2` == 1, `cycle` ← (`cycle` == SLOTS-1) ? 0 : `cycle`+1. It never changes otherwise.
- `sync` is a combinational decode of `cycle`.
- `sys_rst` clears on the edge where `rst` is low, `c2` == 1 and `cycle` == SLOTS-1, i.e. the same edge on which `cycle` wraps to 0. It is never set except by `rst`.
- Guarantees:
  - `c1` and `c2` are never high in the same MCLK cycle.
  - Each fires exactly once per DIV enabled MCLK edges.

## Timing
- Reset values: `c1` = `c2` = `phi_m` = 0, `cycle` = 0, `sync` = 0, `sys_rst` = 1.
- Let E1 be the first edge after `rst` falls, with `clk_en` held high.
  - `c1` is first high in the MCLK cycle after E1, then every DIV MCLK cycles.
  - `c2` is first high after E(1+PHASE2_OFFSET).
  - `cycle` first increments at E(2+PHASE2_OFFSET).
- `sys_rst` falls at E(2+PHASE2_OFFSET+(SLOTS-1)·DIV); with defaults this is E143. At that edge `cycle` returns to 0.
- Reset mid-operation:
  - A pending `c1`/`c2` is dropped.
  - Outputs reach reset values one edge after `rst` is sampled.
  - There are no partial pulses.
- `clk_en` toggling:
  - When `clk_en` goes low, the pulse that would have fired is suppressed.
  - When `clk_en` returns high, the sequence resumes from the held `div_cnt`, with no skipped or duplicated phase.
- `rst` and `clk_en` low together: `rst` wins.

## Configuration
- `YM3438_PHI_M_OUT_EN` defined: `phi_m` operates as described.
- Not defined: `phi_m` is tied to 0 and its register is removed. All other behaviour is identical.

## Test plan
- Reset then release with defaults: `c1` high after E1, E7, E13; `c2` high after E4, E10; never coincident.
- Count `c2` pulses from release: `cycle` reaches 23 and `sync` is 1 after the 23rd `c2`. At E143 `cycle` = 0 and `sys_rst` falls.
- Pulse `clk_en` low for 5 MCLK between `c1` and `c2`: no pulses during the gap, `c2` arrives 5 cycles late, and the period is otherwise unchanged.
- Assert `rst` for 1 MCLK in the middle of frame cycle 10: next cycle `cycle` = 0, `sys_rst` = 1, `c1` = `c2` = 0. The full 143-edge stretch repeats.
- With `YM3438_PHI_M_OUT_EN` and defaults, `phi_m` is 1 for 3 MCLK, then 0 for 3, phase-aligned with `c1`. Without the macro, `phi_m` stays at constant 0.
- Parameter sweep with DIV=4, PHASE2_OFFSET=2, SLOTS=2: `c2` two cycles after `c1`, and `sys_rst` falls at E8.
